// File: rtl/multicycle_control.sv
// Multi-cycle control FSM upstream of the ALU: fetches over an imem handshake, decodes an
// RV32 subset and sequences the shared datapath through the estado codes the ALU acts on.
module multicycle_control #(
    parameter int BRANCH_CYCLES = 3,
    parameter int MEM_TIMEOUT   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        imem_req,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        memwrite,
    output logic [3:0]  estado,
    output logic        alusrc,
    output logic [3:0]  alucontrol,
    output logic        branch,
    output logic [11:0] immediate,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        regwrite,
    output logic        memtoreg,
    output logic        pcwrite,
    output logic        illegal
);

    typedef enum logic [3:0] {
        FETCH     = 4'b0000,
        DECODE    = 4'b0001,
        EXEC_R    = 4'b0010,
        MEM_RD    = 4'b0011,
        MEM_WR    = 4'b0100,
        EXEC_ADDR = 4'b0101,
        EXEC_BR   = 4'b0110,
        WB_ALU    = 4'b0111,
        WB_MEM    = 4'b1000,
        BR_COMMIT = 4'b1001,
        TRAP      = 4'b1111
    } state_t;

    typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_ILLEGAL} kind_t;

    localparam int BW = (BRANCH_CYCLES > 1) ? $clog2(BRANCH_CYCLES) : 1;
    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [BW-1:0] BR_LAST = BW'(BRANCH_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

    state_t        state, next_state;
    kind_t         kind;
    logic [31:0]   ir;
    logic [BW-1:0] br_cnt;
    logic [TW-1:0] wait_cnt;
    logic          handshake, timeout_hit;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign rd     = ir[11:7];
    assign estado = state;

    assign handshake   = state inside {FETCH, MEM_RD, MEM_WR};
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST);

    // Operand controls are a pure function of IR, so they only move on an IR load.
    always_comb begin
        kind       = K_ILLEGAL;
        alusrc     = 1'b0;
        alucontrol = 4'b0000;
        case (opcode)
            7'b0110011: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    kind = K_ALU; alucontrol = 4'b0010;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    kind = K_ALU; alucontrol = 4'b0110;
                end else if (funct3 == 3'b100 && funct7 == 7'b0000000) begin
                    kind = K_ALU; alucontrol = 4'b0100;
                end else if (funct3 == 3'b101 && funct7 == 7'b0000000) begin
                    kind = K_ALU; alucontrol = 4'b0101;
                end
            end
            7'b0010011: if (funct3 == 3'b000) begin
                kind = K_ALU; alusrc = 1'b1; alucontrol = 4'b0011;
            end
            7'b0000011: if (funct3 == 3'b010) begin
                kind = K_LOAD; alusrc = 1'b1; alucontrol = 4'b0010;
            end
            7'b0100011: if (funct3 == 3'b010) begin
                kind = K_STORE; alusrc = 1'b1; alucontrol = 4'b0010;
            end
            7'b1100011: if (funct3 == 3'b000) begin
                kind = K_BRANCH; alusrc = 1'b1; alucontrol = 4'b0110;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (opcode)
            7'b0100011: immediate = {ir[31:25], ir[11:7]};
            7'b1100011: immediate = {ir[31], ir[7], ir[30:25], ir[11:8]};
            default:    immediate = ir[31:20];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            ir       <= '0;
            br_cnt   <= '0;
            wait_cnt <= '0;
            illegal  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == FETCH && imem_ack) ir <= imem_rdata;
            if (state == EXEC_BR && next_state == EXEC_BR) br_cnt <= br_cnt + 1'b1;
            else                                           br_cnt <= '0;
            if (handshake && next_state == state) wait_cnt <= wait_cnt + 1'b1;
            else                                  wait_cnt <= '0;
            if (next_state == TRAP) illegal <= 1'b1;
        end
    end

    // Acknowledge is tested before the timeout so a last-cycle ack still completes.
    always_comb begin
        next_state = state;
        unique case (state)
            FETCH:     if (imem_ack) next_state = DECODE;
                       else if (timeout_hit) next_state = TRAP;
            DECODE: begin
                case (kind)
                    K_ALU:            next_state = EXEC_R;
                    K_LOAD, K_STORE:  next_state = EXEC_ADDR;
                    K_BRANCH:         next_state = EXEC_BR;
                    default:          next_state = TRAP;
                endcase
            end
            EXEC_R:    next_state = WB_ALU;
            EXEC_ADDR: next_state = (kind == K_STORE) ? MEM_WR : MEM_RD;
            MEM_RD:    if (dmem_ack) next_state = WB_MEM;
                       else if (timeout_hit) next_state = TRAP;
            MEM_WR:    if (dmem_ack) next_state = FETCH;
                       else if (timeout_hit) next_state = TRAP;
            EXEC_BR:   if (br_cnt == BR_LAST) next_state = BR_COMMIT;
            WB_ALU, WB_MEM, BR_COMMIT: next_state = FETCH;
            TRAP:      next_state = TRAP;
            default:   next_state = TRAP;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        imem_req = 1'b0;
        dmem_req = 1'b0;
        memwrite = 1'b0;
        branch   = 1'b0;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        pcwrite  = 1'b0;
        unique case (state)
            FETCH:     imem_req = rst_n;
            MEM_RD:    dmem_req = 1'b1;
            MEM_WR: begin
                dmem_req = 1'b1;
                memwrite = 1'b1;
                pcwrite  = dmem_ack;
            end
            EXEC_BR:   branch = 1'b1;
            BR_COMMIT: begin
                branch  = 1'b1;
                pcwrite = 1'b1;
            end
            WB_ALU: begin
                regwrite = 1'b1;
                pcwrite  = 1'b1;
            end
            WB_MEM: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                pcwrite  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a per-cycle expected trace built from instruction-level rules,
// compared against the DUT every cycle, plus literal spot checks and a timeout instance.
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam int BRC = 3;

    localparam logic [3:0] E_FETCH = 4'h0, E_DEC = 4'h1, E_EXR = 4'h2, E_RD = 4'h3, E_WR = 4'h4,
                           E_ADDR = 4'h5, E_BR = 4'h6, E_WBA = 4'h7, E_WBM = 4'h8, E_BRC = 4'h9,
                           E_TRAP = 4'hF;
    // strobe vector order: {imem_req, dmem_req, memwrite, regwrite, memtoreg, pcwrite, branch}
    localparam logic [6:0] S_IREQ = 7'b1000000, S_DREQ = 7'b0100000, S_MW = 7'b0010000,
                           S_REG = 7'b0001000, S_M2R = 7'b0000100, S_PC = 7'b0000010,
                           S_BR = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0;
    logic        imem_req, dmem_req, memwrite, alusrc, branch, regwrite, memtoreg, pcwrite, illegal;
    logic [3:0]  estado, alucontrol;
    logic [11:0] immediate;
    logic [4:0]  rs1, rs2, rd;

    logic        rst2_n = 1'b0;
    logic [31:0] imem_rdata2 = '0;
    logic        imem_ack2 = 1'b0, dmem_ack2 = 1'b0;
    logic        t_imem_req, t_dmem_req, t_memwrite, t_alusrc, t_branch, t_regwrite, t_memtoreg;
    logic        t_pcwrite, t_illegal;
    logic [3:0]  t_estado, t_alucontrol;
    logic [11:0] t_immediate;
    logic [4:0]  t_rs1, t_rs2, t_rd;

    always #5 clk = ~clk;

    multicycle_control #(.BRANCH_CYCLES(BRC), .MEM_TIMEOUT(0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .imem_req(imem_req), .dmem_ack(dmem_ack), .dmem_req(dmem_req), .memwrite(memwrite),
        .estado(estado), .alusrc(alusrc), .alucontrol(alucontrol), .branch(branch),
        .immediate(immediate), .rs1(rs1), .rs2(rs2), .rd(rd), .regwrite(regwrite),
        .memtoreg(memtoreg), .pcwrite(pcwrite), .illegal(illegal)
    );

    multicycle_control #(.BRANCH_CYCLES(BRC), .MEM_TIMEOUT(5)) dut_to (
        .clk(clk), .rst_n(rst2_n), .imem_rdata(imem_rdata2), .imem_ack(imem_ack2),
        .imem_req(t_imem_req), .dmem_ack(dmem_ack2), .dmem_req(t_dmem_req),
        .memwrite(t_memwrite), .estado(t_estado), .alusrc(t_alusrc),
        .alucontrol(t_alucontrol), .branch(t_branch), .immediate(t_immediate), .rs1(t_rs1),
        .rs2(t_rs2), .rd(t_rd), .regwrite(t_regwrite), .memtoreg(t_memtoreg),
        .pcwrite(t_pcwrite), .illegal(t_illegal)
    );

    typedef enum logic [2:0] {KALU, KLD, KST, KBR, KILL} kind_e;
    typedef struct {
        kind_e       kind;
        logic        alusrc;
        logic [3:0]  aluctl;
        logic [11:0] imm;
    } dec_t;
    typedef struct {
        logic [3:0]  st;
        logic [6:0]  strb;
        logic        iack, dack, ill, chk_ctl, alusrc;
        logic [31:0] rdata;
        logic [3:0]  aluctl;
        logic [11:0] imm;
        logic [4:0]  rs1, rs2, rd;
    } cyc_t;

    cyc_t        q[$];
    dec_t        ctl;
    logic [31:0] ctl_word, fetch_word;
    bit          ctl_valid, trapped;
    int          n_tests = 0, n_fail = 0;
    int          n_br = 0, n_pc = 0, n_rw = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    function automatic dec_t model_decode(input logic [31:0] w);
        dec_t d;
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        d.kind = KILL; d.alusrc = 1'b0; d.aluctl = 4'b0000;
        if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0000000)      begin d.kind = KALU; d.aluctl = 4'b0010; end
        else if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0100000) begin d.kind = KALU; d.aluctl = 4'b0110; end
        else if (op == 7'b0110011 && f3 == 3'b100 && f7 == 7'b0000000) begin d.kind = KALU; d.aluctl = 4'b0100; end
        else if (op == 7'b0110011 && f3 == 3'b101 && f7 == 7'b0000000) begin d.kind = KALU; d.aluctl = 4'b0101; end
        else if (op == 7'b0010011 && f3 == 3'b000) begin d.kind = KALU; d.alusrc = 1'b1; d.aluctl = 4'b0011; end
        else if (op == 7'b0000011 && f3 == 3'b010) begin d.kind = KLD;  d.alusrc = 1'b1; d.aluctl = 4'b0010; end
        else if (op == 7'b0100011 && f3 == 3'b010) begin d.kind = KST;  d.alusrc = 1'b1; d.aluctl = 4'b0010; end
        else if (op == 7'b1100011 && f3 == 3'b000) begin d.kind = KBR;  d.alusrc = 1'b1; d.aluctl = 4'b0110; end
        if (d.kind == KST)      d.imm = {w[31:25], w[11:7]};
        else if (d.kind == KBR) d.imm = {w[31], w[7], w[30:25], w[11:8]};
        else                    d.imm = w[31:20];
        return d;
    endfunction

    task automatic model_reset();
        ctl_word = '0; ctl.kind = KILL; ctl.alusrc = 1'b0; ctl.aluctl = 4'b0000; ctl.imm = '0;
        ctl_valid = 1'b1; trapped = 1'b0; fetch_word = '0;
        q.delete();
    endtask

    task automatic add_cycle(input logic [3:0] st, input logic [6:0] strb, input logic ia, input logic da);
        cyc_t c;
        c.st = st; c.strb = strb; c.iack = ia; c.dack = da; c.rdata = fetch_word; c.ill = trapped;
        c.chk_ctl = ctl_valid; c.alusrc = ctl.alusrc; c.aluctl = ctl.aluctl; c.imm = ctl.imm;
        c.rs1 = ctl_word[19:15]; c.rs2 = ctl_word[24:20]; c.rd = ctl_word[11:7];
        q.push_back(c);
    endtask

    // Expected trace of one instruction: ilat idle fetch cycles, dlat idle data cycles.
    task automatic push_instr(input logic [31:0] word, input int ilat, input int dlat);
        dec_t d;
        d = model_decode(word);
        fetch_word = word;
        repeat (ilat) add_cycle(E_FETCH, S_IREQ, 1'b0, 1'b0);
        add_cycle(E_FETCH, S_IREQ, 1'b1, 1'b0);
        ctl = d; ctl_word = word; ctl_valid = (d.kind != KILL);
        add_cycle(E_DEC, 7'b0, 1'b0, 1'b0);
        case (d.kind)
            KALU: begin
                add_cycle(E_EXR, 7'b0, 1'b0, 1'b0);
                add_cycle(E_WBA, S_REG | S_PC, 1'b0, 1'b0);
            end
            KLD: begin
                add_cycle(E_ADDR, 7'b0, 1'b0, 1'b0);
                repeat (dlat) add_cycle(E_RD, S_DREQ, 1'b0, 1'b0);
                add_cycle(E_RD, S_DREQ, 1'b0, 1'b1);
                add_cycle(E_WBM, S_REG | S_M2R | S_PC, 1'b0, 1'b0);
            end
            KST: begin
                add_cycle(E_ADDR, 7'b0, 1'b0, 1'b0);
                repeat (dlat) add_cycle(E_WR, S_DREQ | S_MW, 1'b0, 1'b0);
                add_cycle(E_WR, S_DREQ | S_MW | S_PC, 1'b0, 1'b1);
            end
            KBR: begin
                repeat (BRC) add_cycle(E_BR, S_BR, 1'b0, 1'b0);
                add_cycle(E_BRC, S_BR | S_PC, 1'b0, 1'b0);
            end
            default: begin
                trapped = 1'b1;
                repeat (4) add_cycle(E_TRAP, 7'b0, 1'b0, 1'b0);
            end
        endcase
    endtask

    task automatic run_trace(input int n);
        cyc_t c;
        for (int k = 0; k < n && q.size() > 0; k++) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            imem_ack   = c.iack;
            imem_rdata = c.iack ? c.rdata : 32'hDEADBEEF;
            dmem_ack   = c.dack;
            @(negedge clk);
            check("estado", estado, c.st);
            check("strobes", {imem_req, dmem_req, memwrite, regwrite, memtoreg, pcwrite, branch}, c.strb);
            check("illegal", illegal, c.ill);
            check("regfields", {rs1, rs2, rd}, {c.rs1, c.rs2, c.rd});
            if (c.chk_ctl) begin
                check("alusrc", alusrc, c.alusrc);
                check("alucontrol", alucontrol, c.aluctl);
                check("immediate", immediate, c.imm);
            end
            if (estado == E_BR) n_br++;
            if (pcwrite) n_pc++;
            if (regwrite) n_rw++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        check("rst_estado", estado, 4'h0);
        check("rst_strobes", {imem_req, dmem_req, memwrite, regwrite, memtoreg, pcwrite, branch}, 7'b0);
        check("rst_ctl", {alusrc, alucontrol, illegal}, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        n_br = 0; n_pc = 0; n_rw = 0;
    endtask

    task automatic run_timeout(input bit ack_mode);
        logic [3:0] exp_st;
        @(negedge clk);
        rst2_n = 1'b0; imem_ack2 = 1'b0; imem_rdata2 = 32'h002081B3;
        @(negedge clk);
        rst2_n = 1'b1;
        for (int j = 0; j <= 6; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
                imem_ack2 = ack_mode && (j == 4);
                @(negedge clk);
            end else begin
                #1;
            end
            if (j < 5)        exp_st = E_FETCH;
            else if (!ack_mode) exp_st = E_TRAP;
            else              exp_st = (j == 5) ? E_DEC : E_EXR;
            check("to_estado", t_estado, exp_st);
            check("to_imem_req", t_imem_req, (j < 5));
            check("to_illegal", t_illegal, (!ack_mode && j >= 5));
            check("to_strobes", {t_dmem_req, t_memwrite, t_regwrite, t_memtoreg, t_pcwrite, t_branch}, 6'b0);
            if (j < 5) check("to_ctl", {t_alusrc, t_alucontrol, t_immediate, t_rs1, t_rs2, t_rd}, 32'h0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();

        push_instr(32'h002081B3, 1, 0);               // add x3,x1,x2
        run_trace(1000);
        check("add_alucontrol", alucontrol, 4'b0010);
        check("add_rd", rd, 5'd3);
        check("add_pcwrite_pulses", n_pc, 1);

        push_instr(32'h402081B3, 0, 0);               // sub
        push_instr(32'h0020C1B3, 2, 0);               // xor
        push_instr(32'h0020D1B3, 0, 0);               // srl
        push_instr(32'h00500093, 1, 0);               // addi x1,x0,5
        run_trace(1000);

        n_pc = 0; n_rw = 0;
        push_instr(32'h0080A283, 0, 4);               // lw x5,8(x1)
        run_trace(1000);
        check("lw_immediate", immediate, 12'h008);
        check("lw_rd", rd, 5'd5);
        check("lw_wb_strobes", {memtoreg, regwrite, pcwrite}, 3'b111);

        n_br = 0; n_pc = 0;
        push_instr(32'h00208863, 0, 0);               // beq x1,x2,+16
        run_trace(1000);
        check("beq_exec_cycles", n_br, 3);
        check("beq_immediate", immediate, 12'h008);
        check("beq_commit", {branch, pcwrite, estado}, {2'b11, 4'h9});

        n_pc = 0; n_rw = 0;
        push_instr(32'h0020A223, 1, 2);               // sw x2,4(x1)
        push_instr(32'h0020A223, 0, 0);
        run_trace(1000);
        check("sw_immediate", immediate, 12'h004);
        check("sw_no_regwrite", n_rw, 0);
        check("sw_pcwrite_pulses", n_pc, 2);

        n_pc = 0;
        push_instr(32'hFFFFFFFF, 0, 0);
        run_trace(1000);
        check("trap_estado", estado, 4'hF);
        check("trap_illegal", illegal, 1'b1);
        check("trap_no_pcwrite", n_pc, 0);

        do_reset();
        push_instr(32'h0080A283, 0, 8);
        run_trace(6);
        check("mid_state_is_mem_rd", estado, 4'h3);
        do_reset();
        push_instr(32'h002081B3, 0, 0);
        run_trace(1000);

        push_instr(32'h022081B3, 1, 0);               // bad funct7
        run_trace(1000);
        do_reset();

        run_timeout(1'b0);
        run_timeout(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
